lisnoc_packet_tx: RTL and testbench
===================================

LISNOC_PACKET_TX -- requirements
Module: lisnoc_packet_tx

Interface
REQ-001 SHALL have parameter flit_data_width, default 32, flit data field width.
REQ-002 SHALL have parameter flit_type_width, default 2, flit type field width.
REQ-003 SHALL have parameter dest_width, default 5, destination field width.
REQ-004 SHALL have parameter len_width, default 4, payload-length field width; max payload = 2^len_width-1 flits.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous, active-low reset.
REQ-007 SHALL have port cmd_valid, input, 1, packet command offered.
REQ-008 SHALL have port cmd_ready, output, 1, command accepted this cycle when high with cmd_valid.
REQ-009 SHALL have port cmd_dest, input, dest_width, packet destination.
REQ-010 SHALL have port cmd_len, input, len_width, payload flit count (0 allowed).
REQ-011 SHALL have port data_in, input, flit_data_width, payload word.
REQ-012 SHALL have port data_valid, input, 1, payload word offered.
REQ-013 SHALL have port data_ready, output, 1, payload word accepted when high with data_valid.
REQ-014 SHALL have port out_flit, output, flit_type_width+flit_data_width, {type, data}; connects to FIFO in_flit.
REQ-015 SHALL have port out_valid, output, 1, flit offered to FIFO.
REQ-016 SHALL have port out_ready, input, 1, FIFO accepting.
REQ-017 SHALL have port busy, output, 1, high when state != IDLE or out_valid.
REQ-018 SHALL have port pkt_count, output, 16, completed packets sent, wraps 0xFFFF->0.

Function
REQ-019 SHALL encode types: PAYLOAD=2'b00, HEADER=2'b01, LAST=2'b10, SINGLE=2'b11.
REQ-020 SHALL form header data: bits [flit_data_width-1 -: dest_width]=cmd_dest, bits [len_width-1:0]=cmd_len, all other bits 0.
REQ-021 SHALL implement FSM states IDLE and BODY, plus remaining-count register rem (len_width bits).
REQ-022 SHALL hold one-entry output register; slot free = !out_valid || out_ready.
REQ-023 SHALL drive cmd_ready = (state==IDLE) && slot free; data_ready = (state==BODY) && slot free; both combinational, never both high.
REQ-024 On cmd handshake, SHALL load header next edge: type HEADER if cmd_len>0 else SINGLE; rem<=cmd_len; state<=BODY if cmd_len>0 else stays IDLE.
REQ-025 On data handshake in BODY, SHALL load {PAYLOAD, data_in} if rem>1, else {LAST, data_in}; rem<=rem-1; state<=IDLE when rem==1.
REQ-026 SHALL set out_valid<=0 on out handshake with no new load same cycle; new load and drain in same cycle keeps out_valid=1 (one flit per cycle sustained).
REQ-027 SHALL hold out_flit and out_valid stable while out_valid && !out_ready.
REQ-028 Latency: flit appears on out_flit exactly one cycle after its cmd/data handshake.
REQ-029 SHALL increment pkt_count on out handshake of a LAST or SINGLE flit.
REQ-030 SHALL ignore data_valid in IDLE and cmd_valid in BODY (no acceptance, no state change).

Reset
REQ-031 While rst==0 at a clock edge: state=IDLE, rem=0, out_valid=0, out_flit=0, pkt_count=0; cmd_ready/data_ready low during reset cycle.
REQ-032 Reset mid-packet SHALL discard the partial packet and pending output flit; no LAST generated.

Verification
REQ-033 cmd dest=3 len=0, out_ready=1 -> next cycle out_flit={11, 0x18000000}, pkt_count=1 after handshake.
REQ-034 cmd dest=1 len=3, data 0xA,0xB,0xC back-to-back, out_ready=1 -> HEADER, PAYLOAD 0xA, PAYLOAD 0xB, LAST 0xC on four consecutive cycles; cmd_ready low until LAST loaded.
REQ-035 len=2, out_ready=0 for 3 cycles after header -> header held stable, data_ready=0, no flit lost or duplicated.
REQ-036 rst=0 after 1 payload of len=4 packet -> out_valid=0, busy=0, pkt_count=0; following len=0 command sends clean SINGLE.
REQ-037 65536 SINGLE packets -> pkt_count wraps to 0.

Source files
------------

// File: rtl/lisnoc_packet_tx.sv
// lisnoc_packet_tx
//
// Turns a packet command (destination + payload length) and a stream of
// payload words into a sequence of NoC flits.  A packet with payload is sent
// as HEADER, PAYLOAD..., LAST.  A packet with zero payload is sent as one
// SINGLE flit.  Each flit is placed in a one-entry output register that feeds
// a FIFO.  The register can be refilled in the same cycle it drains, so
// back-to-back traffic moves one flit per cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   cmd_valid   packet command offered
//   cmd_ready   command accepted this cycle (with cmd_valid)
//   cmd_dest    packet destination
//   cmd_len     payload flit count, 0 allowed
//   data_in     payload word
//   data_valid  payload word offered
//   data_ready  payload word accepted this cycle (with data_valid)
//   out_flit    {type, data} toward the FIFO
//   out_valid   out_flit holds a flit
//   out_ready   FIFO accepts out_flit this cycle
//   busy        a packet is in progress or a flit is still pending
//   pkt_count   number of completed packets sent (wraps)
module lisnoc_packet_tx #(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int dest_width      = 5,
    parameter int len_width       = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       cmd_valid,
    output logic                                       cmd_ready,
    input  logic [dest_width-1:0]                      cmd_dest,
    input  logic [len_width-1:0]                       cmd_len,
    input  logic [flit_data_width-1:0]                 data_in,
    input  logic                                       data_valid,
    output logic                                       data_ready,
    output logic [flit_type_width+flit_data_width-1:0] out_flit,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       busy,
    output logic [15:0]                                pkt_count
);

    localparam int FLIT_W = flit_type_width + flit_data_width;

    localparam logic [flit_type_width-1:0] TYPE_PAYLOAD = flit_type_width'(2'b00);
    localparam logic [flit_type_width-1:0] TYPE_HEADER  = flit_type_width'(2'b01);
    localparam logic [flit_type_width-1:0] TYPE_LAST    = flit_type_width'(2'b10);
    localparam logic [flit_type_width-1:0] TYPE_SINGLE  = flit_type_width'(2'b11);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BODY = 1'b1;

    logic                       state;
    logic [len_width-1:0]       rem;
    logic                       slot_free;
    logic                       cmd_hs;
    logic                       data_hs;
    logic                       out_hs;
    logic [flit_type_width-1:0] out_type;
    logic                       out_is_end;

    // Header data: destination in the top bits, length in the low bits.
    function automatic logic [flit_data_width-1:0] header_data(
        input logic [dest_width-1:0] dest,
        input logic [len_width-1:0]  len
    );
        logic [flit_data_width-1:0] h;
        h = '0;
        h[flit_data_width-1 -: dest_width] = dest;
        h[len_width-1:0] = len;
        return h;
    endfunction

    // The register is free when it is empty, or when it drains this cycle.
    assign slot_free  = !out_valid || out_ready;

    // The readies are forced low while reset is asserted. The state decides
    // which of the two may be high, so they can never be high together.
    assign cmd_ready  = rst && (state == ST_IDLE) && slot_free;
    assign data_ready = rst && (state == ST_BODY) && slot_free;

    assign cmd_hs     = cmd_valid && cmd_ready;
    assign data_hs    = data_valid && data_ready;
    assign out_hs     = out_valid && out_ready;

    assign out_type   = out_flit[FLIT_W-1 -: flit_type_width];
    assign out_is_end = (out_type == TYPE_LAST) || (out_type == TYPE_SINGLE);

    assign busy       = (state != ST_IDLE) || out_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rem       <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            pkt_count <= '0;
        end else begin
            if (cmd_hs) begin
                out_flit  <= {(cmd_len != '0) ? TYPE_HEADER : TYPE_SINGLE,
                              header_data(cmd_dest, cmd_len)};
                out_valid <= 1'b1;
                rem       <= cmd_len;
                if (cmd_len != '0) begin
                    state <= ST_BODY;
                end
            end else if (data_hs) begin
                out_flit  <= {(rem > len_width'(1)) ? TYPE_PAYLOAD : TYPE_LAST, data_in};
                out_valid <= 1'b1;
                rem       <= rem - len_width'(1);
                if (rem == len_width'(1)) begin
                    state <= ST_IDLE;
                end
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end

            // A packet counts as complete when its final flit leaves.
            if (out_hs && out_is_end) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lisnoc_packet_tx.sv
// Self-checking bench for lisnoc_packet_tx.
// The reference model is a scoreboard queue of expected flits. It is built
// from accepted commands and payload words, and popped when the FIFO takes
// a flit. Directed scenarios run first, then randomized traffic, then the
// pkt_count wrap.
module tb_lisnoc_packet_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_dest;
    logic [3:0]  cmd_len;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [33:0] out_flit;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] pkt_count;

    int vectors = 0;
    int errors  = 0;

    lisnoc_packet_tx dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dest   (cmd_dest),
        .cmd_len    (cmd_len),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [33:0] m_q[$];     // flit sitting in the output register, if any
    bit          m_in_pkt;   // command accepted, payload still owed
    int          m_rem;      // payload words still owed
    logic [15:0] m_cnt;      // completed packets
    bit          synced = 0; // model valid once a reset has been seen

    function automatic logic [31:0] hdr(input logic [4:0] d, input logic [3:0] l);
        return ({27'd0, d} << 27) | {28'd0, l};
    endfunction

    always @(negedge clk) begin : monitor
        bit          pend;
        bit          slot;
        bit          c_hs;
        bit          d_hs;
        logic [33:0] f;
        pend = (m_q.size() != 0);
        slot = !pend || out_ready;
        if (synced) begin
            check("out_valid", out_valid, pend);
            if (pend) check("out_flit", out_flit, m_q[0]);
            check("pkt_count", pkt_count, m_cnt);
            check("busy", busy, m_in_pkt || pend);
            check("cmd_ready", cmd_ready, rst && !m_in_pkt && slot);
            check("data_ready", data_ready, rst && m_in_pkt && slot);
        end
        if (!rst) begin
            synced   = 1;
            m_q.delete();
            m_in_pkt = 0;
            m_rem    = 0;
            m_cnt    = '0;
        end else if (synced) begin
            c_hs = cmd_valid && !m_in_pkt && slot;
            d_hs = data_valid && m_in_pkt && slot;
            if (pend && out_ready) begin
                f = m_q.pop_front();
                if (f[33:32] == 2'b10 || f[33:32] == 2'b11) m_cnt = m_cnt + 16'd1;
            end
            if (c_hs) begin
                m_q.push_back({(cmd_len == 0) ? 2'b11 : 2'b01, hdr(cmd_dest, cmd_len)});
                m_rem    = int'(cmd_len);
                m_in_pkt = (cmd_len != 0);
            end else if (d_hs) begin
                m_q.push_back({(m_rem == 1) ? 2'b10 : 2'b00, data_in});
                m_rem    = m_rem - 1;
                m_in_pkt = (m_rem != 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 0; cmd_dest = '0; cmd_len = '0;
        data_in = '0; data_valid = 0; out_ready = 1;

        // reset state
        repeat (3) tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_flit", out_flit, 34'd0);
        check("rst_pkt_count", pkt_count, 16'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);

        // zero-length packet -> SINGLE
        rst = 1'b1;
        cmd_valid = 1; cmd_dest = 5'd3; cmd_len = 4'd0;
        tick();
        cmd_valid = 0;
        check("single_flit", out_flit, {2'b11, 32'h1800_0000});
        check("single_valid", out_valid, 1'b1);
        tick();
        check("single_count", pkt_count, 16'd1);

        // len=3, back-to-back payload
        cmd_valid = 1; cmd_dest = 5'd1; cmd_len = 4'd3;
        tick();
        cmd_valid = 0;
        check("b2b_header", out_flit, {2'b01, 32'h0800_0003});
        data_valid = 1; data_in = 32'hA;
        tick();
        check("b2b_pay_a", out_flit, {2'b00, 32'hA});
        check("b2b_cmd_rdy", cmd_ready, 1'b0);
        data_in = 32'hB;
        tick();
        check("b2b_pay_b", out_flit, {2'b00, 32'hB});
        data_in = 32'hC;
        tick();
        check("b2b_last", out_flit, {2'b10, 32'hC});
        check("b2b_valid", out_valid, 1'b1);
        data_valid = 0;
        tick();
        check("b2b_count", pkt_count, 16'd2);

        // len=2 with backpressure after the header
        cmd_valid = 1; cmd_dest = 5'd7; cmd_len = 4'd2;
        tick();
        cmd_valid = 0; out_ready = 0; data_valid = 1; data_in = 32'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_flit", out_flit, {2'b01, 32'h3800_0002});
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_data_rdy", data_ready, 1'b0);
        end
        out_ready = 1;
        tick();
        check("bp_pay", out_flit, {2'b00, 32'h11});
        data_in = 32'h22;
        tick();
        check("bp_last", out_flit, {2'b10, 32'h22});
        data_valid = 0;
        tick();
        check("bp_count", pkt_count, 16'd3);

        // reset mid-packet
        cmd_valid = 1; cmd_dest = 5'd5; cmd_len = 4'd4;
        tick();
        cmd_valid = 0; data_valid = 1; data_in = 32'h55;
        tick();
        data_valid = 0; rst = 0;
        tick();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_count", pkt_count, 16'd0);
        rst = 1; cmd_valid = 1; cmd_dest = 5'd2; cmd_len = 4'd0;
        tick();
        cmd_valid = 0;
        check("post_rst_single", out_flit, {2'b11, 32'h1000_0000});
        tick();
        check("post_rst_count", pkt_count, 16'd1);

        // randomized traffic, checked by the scoreboard monitor
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) != 0);
            cmd_valid  = ($urandom_range(0, 3) != 0);
            cmd_dest   = 5'($urandom);
            cmd_len    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
            data_valid = ($urandom_range(0, 9) < 7);
            data_in    = $urandom;
            out_ready  = ($urandom_range(0, 9) < 7);
            tick();
        end

        // pkt_count wrap after 65536 SINGLE packets
        rst = 0; cmd_valid = 0; data_valid = 0; out_ready = 1;
        tick();
        rst = 1; cmd_valid = 1; cmd_dest = 5'd9; cmd_len = 4'd0;
        repeat (65536) @(posedge clk);
        #1;
        check("wrap_ffff", pkt_count, 16'hFFFF);
        cmd_valid = 0;
        tick();
        check("wrap_zero", pkt_count, 16'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
